// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the host register-bus master.
package reg_bus_pkg;

  localparam int         HDR_DIR_BIT = 7;
  localparam logic [6:0] CMD_MASK    = 7'h7F;
  localparam int         LEN_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_WDATA,
    ST_RD_ISSUE,
    ST_RD_WAIT
  } bus_state_t;

  // Register address carried by a header byte; the direction bit is not part of it.
  function automatic logic [7:0] hdr_to_cmd(input logic [7:0] hdr);
    return {1'b0, hdr[6:0] & CMD_MASK};
  endfunction

  // States that wait on the host and are therefore guarded by the inactivity timer.
  function automatic logic is_timed_state(input bus_state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_WDATA);
  endfunction

endpackage

// File: rtl/reg_bus_master_inactivity_timer.sv
// Host inactivity timer: a down-counter reloaded on clear, terminal count flags expiry.
module inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMER_W        = 20
) (
  input  logic clk_usb,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TERM_VAL = TIMER_W'(1);

  logic [TIMER_W-1:0] remaining;

  // Reload on clear, otherwise count down while enabled; stop at zero so it never wraps.
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= LOAD_VAL;
    end else if (enable && (remaining != '0)) begin
      remaining <= remaining - TIMER_W'(1);
    end
  end

  // The last idle cycle of the allowed window is the one that sees the terminal count.
  always_comb begin
    expired = enable && !clear && (remaining == TERM_VAL);
  end

endmodule

// File: rtl/reg_bus_master.sv
// Host-side register bus master: turns the UART byte stream into register
// reads/writes and streams read data back towards the UART transmitter.
//
//  state       | meaning
//  ------------+--------------------------------------------------------------
//  ST_IDLE     | waiting for a header byte (direction + register address)
//  ST_LEN0     | waiting for the low length byte
//  ST_LEN1     | waiting for the high length byte; zero length ends the frame
//  ST_WDATA    | each host byte becomes a one-cycle reg_write strobe
//  ST_RD_ISSUE | one-cycle reg_read strobe, read data captured into tx_data
//  ST_RD_WAIT  | holding tx_data until the transmitter accepts it
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMER_W        = 20
) (
  input  logic             clk_usb,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       reg_cmd,
  output logic [LEN_W-1:0] reg_bytecount,
  output logic [7:0]       reg_data_in,
  input  logic [7:0]       reg_data_out,
  output logic             reg_read,
  output logic             reg_write,
  output logic             busy,
  output logic             timeout_err
);

  bus_state_t       state;
  bus_state_t       state_next;
  logic             dir_write;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] len_full;
  logic             len_zero;
  logic             wr_accept;
  logic             wr_last;
  logic             tx_hs;
  logic             idx_last;
  logic             tmr_clear;
  logic             tmr_enable;
  logic             tmr_expired;

  inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_timer (
    .clk_usb(clk_usb),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  // State register.
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the combinational strobes/qualifiers derived from it.
  always_comb begin
    state_next = state;
    len_full   = {rx_data, len_lo};
    len_zero   = (len_full == '0);
    idx_last   = (reg_bytecount == last_idx);
    wr_last    = reg_write && idx_last;
    wr_accept  = 1'b0;
    tx_hs      = tx_valid && tx_ready;
    tmr_clear  = rx_valid;
    tmr_enable = is_timed_state(state);
    reg_read   = 1'b0;
    busy       = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (rx_valid) state_next = ST_LEN0;
      end
      ST_LEN0: begin
        if (tmr_expired)   state_next = ST_IDLE;
        else if (rx_valid) state_next = ST_LEN1;
      end
      ST_LEN1: begin
        if (tmr_expired) begin
          state_next = ST_IDLE;
        end else if (rx_valid) begin
          if (len_zero)       state_next = ST_IDLE;
          else if (dir_write) state_next = ST_WDATA;
          else                state_next = ST_RD_ISSUE;
        end
      end
      ST_WDATA: begin
        // A byte arriving alongside the final strobe is surplus and is dropped.
        wr_accept = rx_valid && !wr_last;
        if (tmr_expired || wr_last) state_next = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        reg_read   = 1'b1;
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (tx_hs) state_next = idx_last ? ST_IDLE : ST_RD_ISSUE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transaction registers: header fields, length, byte index, write data and tx holding register.
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      reg_cmd       <= '0;
      dir_write     <= 1'b0;
      len_lo        <= '0;
      last_idx      <= '0;
      reg_bytecount <= '0;
      reg_data_in   <= '0;
      reg_write     <= 1'b0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      timeout_err <= tmr_expired;
      reg_write   <= wr_accept;
      if (wr_accept) reg_data_in <= rx_data;

      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            reg_cmd   <= hdr_to_cmd(rx_data);
            dir_write <= rx_data[HDR_DIR_BIT];
          end
        end
        ST_LEN0: begin
          if (rx_valid) len_lo <= rx_data;
        end
        ST_LEN1: begin
          if (rx_valid && !len_zero) begin
            last_idx      <= len_full - LEN_W'(1);
            reg_bytecount <= '0;
          end
        end
        ST_WDATA: begin
          // Index advances the cycle after its strobe; the final index is held.
          if (reg_write && !idx_last) reg_bytecount <= reg_bytecount + LEN_W'(1);
        end
        ST_RD_ISSUE: begin
          tx_data  <= reg_data_out;
          tx_valid <= 1'b1;
        end
        ST_RD_WAIT: begin
          if (tx_hs) begin
            tx_valid <= 1'b0;
            if (!idx_last) reg_bytecount <= reg_bytecount + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master: expected strobes/tx bytes are queued when
// host bytes are driven and popped as the DUT produces them.
module tb_reg_bus_master;

  localparam int TO = 50;

  logic        clk_usb = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        reg_read;
  logic        reg_write;
  logic        busy;
  logic        timeout_err;

  reg_bus_master #(.TIMEOUT_CYCLES(TO), .TIMER_W(20)) dut (
    .clk_usb      (clk_usb),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .reg_cmd      (reg_cmd),
    .reg_bytecount(reg_bytecount),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .reg_read     (reg_read),
    .reg_write    (reg_write),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk_usb = ~clk_usb;

  // Peripheral model: read data is the byte index plus 0x50.
  assign reg_data_out = reg_read ? (reg_bytecount[7:0] + 8'h50) : 8'h00;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int cyc = 0;
  int n_wr = 0, n_rd = 0, n_hs = 0, n_to = 0;
  int overlap = 0, rd_wide = 0;
  int last_rx_cyc = 0, to_cyc = 0;
  logic prev_read = 1'b0;
  logic rdy_rand = 1'b0;
  logic rdy_force = 1'b1;

  always @(posedge clk_usb) cyc <= cyc + 1;

  always @(posedge clk_usb) begin
    #1;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor: sample mid-cycle, pop scoreboards on strobes and handshakes.
  always @(negedge clk_usb) begin
    if (!reset) begin
      if (reg_read && reg_write) overlap++;
      if (reg_read && prev_read) rd_wide++;
      prev_read = reg_read;
      if (rx_valid) last_rx_cyc = cyc;
      if (timeout_err) begin
        n_to++;
        to_cyc = cyc;
      end
      if (reg_read) n_rd++;
      if (reg_write) begin
        n_wr++;
        chk("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) chk("wr_strobe", {reg_cmd, reg_bytecount, reg_data_in}, wr_q.pop_front());
      end
      if (tx_valid && tx_ready) begin
        n_hs++;
        chk("rd_before_tx", n_rd, n_hs);
        chk("tx_expected", 64'(tx_q.size() != 0), 64'd1);
        if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_usb);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_usb);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] h, input logic [15:0] len);
    send_byte(h);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int i = 0;
    while (busy && i < max) begin
      @(posedge clk_usb);
      #1;
      i++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d1[4];
    logic [7:0] held;
    int w0, r0, t0, i, unstable;

    d1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2;
    chk("rst_outputs", {tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in,
                        reg_read, reg_write, busy, timeout_err}, 64'd0);
    repeat (3) @(posedge clk_usb);
    #1;
    reset = 1'b0;
    idle(2);

    // 1: back-to-back write of four bytes
    w0 = n_wr;
    send_hdr(8'hA7, 16'd4);
    for (int k = 0; k < 4; k++) begin
      wr_q.push_back({8'h27, 16'(k), d1[k]});
      send_byte(d1[k]);
    end
    wait_idle(20, "t1_busy");
    chk("t1_nwr", n_wr - w0, 4);
    chk("t1_q", wr_q.size(), 0);
    chk("t1_cmd_held", reg_cmd, 8'h27);
    chk("t1_idx_held", reg_bytecount, 16'd3);

    // 2: read four bytes with random tx_ready
    r0 = n_rd;
    for (int k = 0; k < 4; k++) tx_q.push_back(8'h50 + 8'(k));
    rdy_rand = 1'b1;
    send_hdr(8'h27, 16'd4);
    wait_idle(400, "t2_busy");
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;
    chk("t2_nrd", n_rd - r0, 4);
    chk("t2_txq", tx_q.size(), 0);
    chk("t2_txv", tx_valid, 1'b0);
    idle(2);

    // 3: zero-length write, then a normal frame
    w0 = n_wr;
    r0 = n_rd;
    send_hdr(8'h85, 16'd0);
    chk("t3_idle", busy, 1'b0);
    idle(3);
    chk("t3_nwr", n_wr - w0, 0);
    chk("t3_nrd", n_rd - r0, 0);
    wr_q.push_back({8'h01, 16'h0000, 8'h5A});
    send_hdr(8'h81, 16'd1);
    send_byte(8'h5A);
    wait_idle(10, "t3_next_busy");
    chk("t3_next_nwr", n_wr - w0, 1);
    chk("t3_q", wr_q.size(), 0);

    // 4: write stalls after one byte and times out
    w0 = n_wr;
    t0 = n_to;
    send_hdr(8'h90, 16'd3);
    wr_q.push_back({8'h10, 16'h0000, 8'hC3});
    send_byte(8'hC3);
    idle(40);
    chk("t4_not_early", busy, 1'b1);
    chk("t4_no_pulse_yet", n_to - t0, 0);
    i = 0;
    while (n_to == t0 && i < 30) begin
      @(posedge clk_usb);
      #1;
      i++;
    end
    chk("t4_pulse", n_to - t0, 1);
    chk("t4_latency_ok", 64'((to_cyc - last_rx_cyc >= TO) && (to_cyc - last_rx_cyc <= TO + 1)), 64'd1);
    chk("t4_idle", busy, 1'b0);
    idle(3);
    chk("t4_one_pulse", n_to - t0, 1);
    chk("t4_nwr", n_wr - w0, 1);
    wr_q.push_back({8'h02, 16'h0000, 8'h77});
    send_hdr(8'h82, 16'd1);
    send_byte(8'h77);
    wait_idle(10, "t4_next_busy");
    chk("t4_q", wr_q.size(), 0);

    // 5: read stalled by tx_ready with host bytes arriving
    rdy_force = 1'b0;
    idle(1);
    w0 = n_wr;
    r0 = n_rd;
    t0 = n_to;
    tx_q.push_back(8'h50);
    tx_q.push_back(8'h51);
    send_hdr(8'h05, 16'd2);
    idle(3);
    chk("t5_txv", tx_valid, 1'b1);
    chk("t5_tx_first", tx_data, 8'h50);
    held = tx_data;
    unstable = 0;
    for (int k = 0; k < 200; k++) begin
      if (k % 10 == 0) begin
        rx_data  = 8'hA0 + 8'(k / 10);
        rx_valid = 1'b1;
      end
      @(posedge clk_usb);
      #1;
      rx_valid = 1'b0;
      if (!tx_valid || tx_data !== held) unstable++;
    end
    chk("t5_stable", unstable, 0);
    chk("t5_no_timeout", n_to - t0, 0);
    chk("t5_busy", busy, 1'b1);
    chk("t5_one_read", n_rd - r0, 1);
    chk("t5_cmd", reg_cmd, 8'h05);
    rdy_force = 1'b1;
    wait_idle(50, "t5_done");
    chk("t5_nrd", n_rd - r0, 2);
    chk("t5_txq", tx_q.size(), 0);
    chk("t5_nwr", n_wr - w0, 0);

    // 6a: reset during the second data byte of a write
    w0 = n_wr;
    send_hdr(8'h8C, 16'd4);
    wr_q.push_back({8'h0C, 16'h0000, 8'hE1});
    send_byte(8'hE1);
    idle(2);
    rx_data  = 8'hE2;
    rx_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_outputs", {tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in,
                           reg_read, reg_write, busy, timeout_err}, 64'd0);
    @(posedge clk_usb);
    #1;
    rx_valid = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(20);
    chk("t6_nwr", n_wr - w0, 1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_q", wr_q.size(), 0);

    // 6b: reset while a read byte is held for the transmitter
    rdy_force = 1'b0;
    idle(1);
    send_hdr(8'h03, 16'd2);
    idle(3);
    chk("t6b_txv", tx_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6b_txv_rst", tx_valid, 1'b0);
    chk("t6b_busy_rst", busy, 1'b0);
    idle(2);
    reset = 1'b0;
    rdy_force = 1'b1;
    idle(10);
    chk("t6b_txv_after", tx_valid, 1'b0);
    chk("t6b_busy_after", busy, 1'b0);

    chk("rw_overlap", overlap, 0);
    chk("rd_width", rd_wide, 0);
    chk("wr_q_final", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
